// File: rtl/adc16dv160_input_common.sv
// Shared types and constants for the ADC16DV160 capture path.
package adc16dv160_input_common;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain
    } cap_state_e;

    // Bit positions in the AXI-Lite status word.
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_OVF  = 1;
    localparam int unsigned STAT_TMO  = 2;

endpackage

// File: rtl/adc16dv160_capture_ctrl_if.sv
// AXI-Stream sample channel between the capture controller and the DMA.
interface adc16dv160_capture_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] TDATA;
    logic              TVALID;
    logic              TREADY;
    logic              TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/adc16dv160_axis_outreg.sv
// Single-entry AXI-Stream holding register; owns TDATA/TVALID/TLAST.
module adc16dv160_axis_outreg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              force_last_i,
    input  logic              ready_i,
    output logic              full_o,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tlast_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // A load may coincide with the pop of the previous beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (force_last_i) begin
            last_q  <= 1'b1;
        end
    end

    assign full_o  = valid_q;
    assign tdata_o = data_q;
    assign tlast_o = last_q;

endmodule

// File: rtl/adc16dv160_capture_ctrl.sv
// ADC16DV160 capture sequencer: start/size latch, sample selection, AXIS output, status.
// Optional input-idle timeout abort enabled by defining ADC16DV160_CAPTURE_TIMEOUT_EN.
module adc16dv160_capture_ctrl
    import adc16dv160_input_common::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [CNT_W-1:0]    dsize,
    input  logic                cr_start,
    input  logic                cr_test,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    adc16dv160_capture_ctrl_if.master M_AXIS,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                timeout,
    output logic [CNT_W-1:0]    sample_cnt
);

    cap_state_e        state_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [CNT_W-1:0]  dsize_q;
    logic              test_q;
    logic [DATA_W-1:0] tcnt_q;

    logic              full;
    logic              pop;
    logic              room;
    logic              load;
    logic              load_last;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] cand;
    logic              tmo_hit;
    logic              force_last;

    assign pop       = full && M_AXIS.TREADY;
    assign room      = !full || pop;
    assign cand      = test_q ? tcnt_q : adc_data;
    assign cnt_inc   = sample_cnt_q + CNT_W'(1);
    assign load      = (state_q == StCapture) && adc_valid && room;
    assign load_last = (cnt_inc == dsize_q);

`ifdef ADC16DV160_CAPTURE_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt_q;
    logic             timeout_q;

    assign tmo_hit    = (state_q == StCapture) && !adc_valid &&
                        (idle_cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYC));
    assign force_last = tmo_hit && full && !pop;
    assign timeout    = timeout_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
    assign force_last     = 1'b0;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            sample_cnt_q <= '0;
            dsize_q      <= '0;
            test_q       <= 1'b0;
            tcnt_q       <= '0;
`ifdef ADC16DV160_CAPTURE_TIMEOUT_EN
            idle_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cr_start) begin
                        if (dsize != '0) begin
                            dsize_q      <= dsize;
                            test_q       <= cr_test;
                            sample_cnt_q <= '0;
                            overflow_q   <= 1'b0;
                            tcnt_q       <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= StCapture;
`ifdef ADC16DV160_CAPTURE_TIMEOUT_EN
                            idle_cnt_q   <= '0;
                            timeout_q    <= 1'b0;
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StCapture: begin
                    // Test counter advances on dropped samples too.
                    if (adc_valid) begin
                        tcnt_q <= tcnt_q + DATA_W'(1);
                        if (room) begin
                            sample_cnt_q <= cnt_inc;
                            if (load_last) state_q <= StDrain;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
`ifdef ADC16DV160_CAPTURE_TIMEOUT_EN
                    if (adc_valid) begin
                        idle_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        idle_cnt_q <= '0;
                        timeout_q  <= 1'b1;
                        if (full && !pop) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
`endif
                end
                StDrain: begin
                    if (pop && M_AXIS.TLAST) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    adc16dv160_axis_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk          (ACLK),
        .rst          (ARESET),
        .load_i       (load),
        .data_i       (cand),
        .last_i       (load_last),
        .force_last_i (force_last),
        .ready_i      (M_AXIS.TREADY),
        .full_o       (full),
        .tdata_o      (M_AXIS.TDATA),
        .tlast_o      (M_AXIS.TLAST)
    );

    assign M_AXIS.TVALID = full;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign sample_cnt    = sample_cnt_q;

endmodule
